image_fetcher: RTL and testbench
================================

IMAGE_FETCHER -- requirements
Module: image_fetcher

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 16: pixels per frame.
REQ-002 SHALL have parameter ADDR_W, default 4: pixel address width; NUM_PIXELS <= 2**ADDR_W.
REQ-003 SHALL have parameter THRESH, default 128: binarize threshold; used only with IMAGE_FETCHER_BINARIZE_EN.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle request to stream one frame.
REQ-007 SHALL have port mem_addr  output  ADDR_W  registered read address to the image store.
REQ-008 SHALL have port mem_data  input  8  pixel returned by the image store one cycle after mem_addr.
REQ-009 SHALL have port pix_data  output  8  streamed pixel.
REQ-010 SHALL have port pix_valid  output  1  pix_data/pix_idx/pix_last valid.
REQ-011 SHALL have port pix_ready  input  1  consumer accepts.
REQ-012 SHALL have port pix_idx  output  ADDR_W  index of the current pixel.
REQ-013 SHALL have port pix_last  output  1  current pixel is index NUM_PIXELS-1.
REQ-014 SHALL have port busy  output  1  frame in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse after the final handshake.

Function
REQ-016 SHALL implement the FSM IDLE->FETCH on start, FETCH->DRAIN after the last address is issued, and DRAIN->IDLE on the pix_last handshake.
REQ-017 SHALL treat a pixel as issued in the cycle its address is on mem_addr, and SHALL capture mem_data exactly one cycle later.
REQ-018 SHALL buffer captured pixels in a 2-entry FIFO; pix_* SHALL come from the FIFO head.
REQ-019 SHALL issue only when FIFO occupancy plus in-flight reads minus the same-cycle pop is less than 2, so no pixel is ever dropped.
REQ-020 SHALL sustain one pixel per cycle while pix_ready is held high.
REQ-021 SHALL assert pix_valid after the second rising edge following the edge that samples start.
REQ-022 SHALL complete a handshake only when pix_valid and pix_ready are both high, and SHALL hold pix_* stable while pix_valid is high and pix_ready is low.
REQ-023 SHALL issue addresses 0 to NUM_PIXELS-1 in order with no repeats or skips.
REQ-024 SHALL hold mem_addr once the last address has been issued.
REQ-025 SHALL keep busy high from the edge after start is sampled until the edge of the final handshake.
REQ-026 SHALL ignore start while busy is high.
REQ-027 SHALL assert done for exactly one cycle after the final handshake.
REQ-028 SHALL accept a start in the same cycle as done and begin a new frame.

Reset
REQ-029 SHALL on rst force state IDLE, mem_addr=0, FIFO empty, in-flight flag clear, pix_valid=0, pix_data=0, pix_idx=0, pix_last=0, busy=0, done=0.
REQ-030 SHALL on rst mid-frame discard any in-flight read and SHALL produce no further pixels until a new start.

Configuration
REQ-031 SHALL, with IMAGE_FETCHER_BINARIZE_EN defined, output pix_data = 8'hFF when the captured pixel >= THRESH and 8'h00 otherwise, applied at FIFO write with no added latency.
REQ-032 SHALL, without IMAGE_FETCHER_BINARIZE_EN, output the raw mem_data value.

Structure
REQ-033 SHALL place the FSM state enum and the default NUM_PIXELS/ADDR_W constants in shared package image_pkg.
REQ-034 SHALL implement the 2-entry buffer as sub-module pixel_skid_fifo (8-bit data plus index/last sideband, with count output).

Verification
REQ-035 SHALL verify, using a 1-cycle-latency ROM model with mem[i]=16*i+1, that start with pix_ready held high yields pixels 1,17,...,241 with idx 0..15 on 16 consecutive cycles, pix_last on idx 15, and done the cycle after.
REQ-036 SHALL verify that toggling pix_ready 1,0,0,1,... gives all 16 pixels in order with no loss or duplicate, and pix_* stable while stalled.
REQ-037 SHALL verify that a second start pulsed at idx 5 is ignored (exactly 16 pixels), while a start coincident with done launches a new frame.
REQ-038 SHALL verify that rst asserted after idx 7 gives pix_valid=0, busy=0, mem_addr=0 immediately, and that the next start streams from idx 0.
REQ-039 SHALL verify that with IMAGE_FETCHER_BINARIZE_EN and THRESH=128, idx 7 (113) gives 8'h00 and idx 8 (129) gives 8'hFF.
REQ-040 SHALL verify that the first pix_valid appears two edges after start is sampled.

Source files
------------

// File: rtl/image_pkg.sv
// Shared types and defaults for the image fetcher: FSM states, frame geometry
// and the pixel binarize helper.
package image_pkg;

  localparam int unsigned NUM_PIXELS_DEF = 16;
  localparam int unsigned ADDR_W_DEF     = 4;
  localparam int unsigned PIX_W          = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic logic [PIX_W-1:0] binarize(input logic [PIX_W-1:0] pix,
                                                input logic [PIX_W-1:0] thresh);
    return (pix >= thresh) ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/pixel_skid_fifo.sv
// Two-entry pixel buffer with index/last sideband; slot 0 is always the head so
// the outputs come straight from registers.
module pixel_skid_fifo
  import image_pkg::*;
#(
  parameter int unsigned IDX_W = ADDR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [PIX_W-1:0] data_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             last_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [PIX_W-1:0] data_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o,
  output logic [1:0]       count_o
);

  logic             v0_q, v0_d, v1_q, v1_d;
  logic [PIX_W-1:0] d0_q, d0_d, d1_q, d1_d;
  logic [IDX_W-1:0] i0_q, i0_d, i1_q, i1_d;
  logic             l0_q, l0_d, l1_q, l1_d;

  // Pop shifts slot 1 into the head, then a push fills the first free slot.
  // The writer guarantees a push never arrives while both slots stay full.
  always_comb begin
    v0_d = v0_q; d0_d = d0_q; i0_d = i0_q; l0_d = l0_q;
    v1_d = v1_q; d1_d = d1_q; i1_d = i1_q; l1_d = l1_q;
    if (pop_i) begin
      v0_d = v1_q; d0_d = d1_q; i0_d = i1_q; l0_d = l1_q;
      v1_d = 1'b0;
    end
    if (push_i) begin
      if (!v0_d) begin
        v0_d = 1'b1; d0_d = data_i; i0_d = idx_i; l0_d = last_i;
      end else begin
        v1_d = 1'b1; d1_d = data_i; i1_d = idx_i; l1_d = last_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_q <= 1'b0; d0_q <= '0; i0_q <= '0; l0_q <= 1'b0;
      v1_q <= 1'b0; d1_q <= '0; i1_q <= '0; l1_q <= 1'b0;
    end else begin
      v0_q <= v0_d; d0_q <= d0_d; i0_q <= i0_d; l0_q <= l0_d;
      v1_q <= v1_d; d1_q <= d1_d; i1_q <= i1_d; l1_q <= l1_d;
    end
  end

  assign valid_o = v0_q;
  assign data_o  = d0_q;
  assign idx_o   = i0_q;
  assign last_o  = l0_q;
  assign count_o = 2'(v0_q) + 2'(v1_q);

endmodule

// File: rtl/image_fetcher.sv
// Streams one frame of pixels from a 1-cycle-latency image store on start.
// Optional IMAGE_FETCHER_BINARIZE_EN thresholds each pixel to 8'h00/8'hFF.
module image_fetcher
  import image_pkg::*;
#(
  parameter int unsigned NUM_PIXELS = NUM_PIXELS_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned THRESH     = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_data,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [ADDR_W-1:0] pix_idx,
  output logic              pix_last,
  output logic              busy,
  output logic              done
);

`ifdef IMAGE_FETCHER_BINARIZE_EN
  localparam bit BINARIZE_EN = 1'b1;
`else
  localparam bit BINARIZE_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              infl_q, infl_d;
  logic [ADDR_W-1:0] infl_idx_q, infl_idx_d;
  logic              infl_last_q, infl_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [1:0]        fifo_count;
  logic [PIX_W-1:0]  wr_data_c;
  logic              pop_c, issue_c, last_issue_c, final_hs_c;

  // Issue only if the buffer can still absorb every read already committed.
  assign pop_c        = pix_valid & pix_ready;
  assign issue_c      = (state_q == ST_FETCH) &&
                        ((3'(fifo_count) + 3'(infl_q)) < (3'(2) + 3'(pop_c)));
  assign last_issue_c = issue_c && (mem_addr_q == LAST_ADDR);
  assign final_hs_c   = pop_c & pix_last;
  assign wr_data_c    = BINARIZE_EN ? binarize(mem_data, PIX_W'(THRESH)) : mem_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start)        state_d = ST_FETCH;
      ST_FETCH: if (last_issue_c) state_d = ST_DRAIN;
      ST_DRAIN: if (final_hs_c)   state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_addr_d  = mem_addr_q;
    infl_d      = issue_c;
    infl_idx_d  = mem_addr_q;
    infl_last_d = (mem_addr_q == LAST_ADDR);
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mem_addr_d = '0;
          busy_d     = 1'b1;
        end
      end
      ST_FETCH: begin
        if (issue_c && !last_issue_c) mem_addr_d = mem_addr_q + ADDR_W'(1);
      end
      ST_DRAIN: begin
        if (final_hs_c) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_q  <= '0;
      infl_q      <= 1'b0;
      infl_idx_q  <= '0;
      infl_last_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      infl_q      <= infl_d;
      infl_idx_q  <= infl_idx_d;
      infl_last_q <= infl_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Read data lands in the buffer the cycle after its address was issued.
  pixel_skid_fifo #(.IDX_W(ADDR_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (infl_q),
    .data_i  (wr_data_c),
    .idx_i   (infl_idx_q),
    .last_i  (infl_last_q),
    .pop_i   (pop_c),
    .valid_o (pix_valid),
    .data_o  (pix_data),
    .idx_o   (pix_idx),
    .last_o  (pix_last),
    .count_o (fifo_count)
  );

  assign mem_addr = mem_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_image_fetcher.sv
// Directed bench for image_fetcher with a 1-cycle-latency ROM (mem[i] = 16*i+1).
// Honours IMAGE_FETCHER_BINARIZE_EN when computing expected pixels.
module tb_image_fetcher;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] mem_addr;
  logic [7:0] mem_data = 8'h00;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic       pix_ready = 1'b0;
  logic [3:0] pix_idx;
  logic       pix_last;
  logic       busy;
  logic       done;

  int n_chk  = 0;
  int n_fail = 0;
  int got;
  bit stalled, done_seen;
  logic [7:0] held_data;
  logic [3:0] held_idx;
  logic       held_last;

  image_fetcher dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_idx   (pix_idx),
    .pix_last  (pix_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= 8'(16 * int'(mem_addr) + 1);

  function automatic logic [7:0] exp_pix(input int i);
    logic [7:0] raw;
    raw = 8'(16 * i + 1);
`ifdef IMAGE_FETCHER_BINARIZE_EN
    return (raw >= 8'd128) ? 8'hFF : 8'h00;
`else
    return raw;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_valid", 32'(pix_valid), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_addr",  32'(mem_addr), 0);
    chk("rst_data",  32'(pix_data), 0);
    chk("rst_idx",   32'(pix_idx), 0);
    chk("rst_last",  32'(pix_last), 0);
    rst = 1'b0;
    tick();

    // Full-rate frame, ready held high
    pix_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("a_busy_start", 32'(busy), 1);
    chk("a_valid_e0", 32'(pix_valid), 0);
    tick();
    chk("a_valid_e1", 32'(pix_valid), 0);
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("a_valid", 32'(pix_valid), 1);
      chk("a_data",  32'(pix_data), 32'(exp_pix(i)));
      chk("a_idx",   32'(pix_idx), 32'(i));
      chk("a_last",  32'(pix_last), 32'(i == 15));
      chk("a_busy",  32'(busy), 1);
      chk("a_done_early", 32'(done), 0);
      tick();
    end
    chk("a_done", 32'(done), 1);
    chk("a_busy_end", 32'(busy), 0);
    chk("a_valid_end", 32'(pix_valid), 0);
    tick();
    chk("a_done_pulse", 32'(done), 0);

    // Backpressure pattern 1,0,0 repeating
    start = 1'b1;
    tick();
    start = 1'b0;
    got = 0; stalled = 0; done_seen = 0;
    for (int cyc = 0; cyc < 200 && !done_seen; cyc++) begin
      pix_ready = ((cyc % 3) == 0);
      if (stalled) begin
        chk("b_hold_valid", 32'(pix_valid), 1);
        chk("b_hold_data",  32'(pix_data), 32'(held_data));
        chk("b_hold_idx",   32'(pix_idx), 32'(held_idx));
        chk("b_hold_last",  32'(pix_last), 32'(held_last));
      end
      stalled = 0;
      if (pix_valid) begin
        if (pix_ready) begin
          chk("b_data", 32'(pix_data), 32'(exp_pix(got)));
          chk("b_idx",  32'(pix_idx), 32'(got));
          chk("b_last", 32'(pix_last), 32'(got == 15));
          got++;
        end else begin
          stalled   = 1;
          held_data = pix_data;
          held_idx  = pix_idx;
          held_last = pix_last;
        end
      end
      tick();
      if (done) done_seen = 1;
    end
    chk("b_count", 32'(got), 16);
    chk("b_done_seen", 32'(done_seen), 1);
    chk("b_valid_after", 32'(pix_valid), 0);
    tick();

    // Start during a frame is ignored; start with done relaunches
    pix_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    for (int i = 0; i < 16; i++) begin
      chk("c_idx",  32'(pix_idx), 32'(i));
      chk("c_data", 32'(pix_data), 32'(exp_pix(i)));
      start = (i == 5);
      tick();
    end
    start = 1'b0;
    chk("c_done", 32'(done), 1);
    chk("c_valid_end", 32'(pix_valid), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("c_restart_busy", 32'(busy), 1);
    chk("c_restart_v0", 32'(pix_valid), 0);
    tick();
    chk("c_restart_v1", 32'(pix_valid), 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("c2_valid", 32'(pix_valid), 1);
      chk("c2_idx",   32'(pix_idx), 32'(i));
      tick();
    end

    // Reset after idx 7 has been accepted
    rst = 1'b1;
    #1;
    chk("d_rst_valid", 32'(pix_valid), 0);
    chk("d_rst_busy",  32'(busy), 0);
    chk("d_rst_addr",  32'(mem_addr), 0);
    chk("d_rst_done",  32'(done), 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("d_quiet_valid", 32'(pix_valid), 0);
      chk("d_quiet_busy",  32'(busy), 0);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    for (int i = 0; i < 16; i++) begin
      chk("e_valid", 32'(pix_valid), 1);
      chk("e_idx",   32'(pix_idx), 32'(i));
      chk("e_data",  32'(pix_data), 32'(exp_pix(i)));
      tick();
    end
    chk("e_done", 32'(done), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
